// File: rtl/decode_dispatch_buffer_if.sv
// +--------------------------------------------------------------------+
// | decode_dispatch_buffer_if                                          |
// | Fetch-bundle / issue-queue bus of the decode dispatch buffer.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface decode_dispatch_buffer_if #(
  parameter int WIDTH  = 4,
  parameter int CNT_W  = $clog2(WIDTH + 1),
  parameter int REQ_W  = 33,
  parameter int ELEM_W = 33
);
  // Request slot: [REQ_W-1] is_valid, [31:0] instruction word.
  logic                             flush;
  logic                             in_valid;
  logic [WIDTH-1:0][REQ_W-1:0]      decode_require;
  logic                             stall_from_decode;
  logic [CNT_W-1:0]                 iq_size_left;
  logic [WIDTH-1:0][ELEM_W-1:0]     issue_queue_element;
  logic [CNT_W-1:0]                 issue_queue_push_number;

  modport master (
    output flush, in_valid, decode_require, iq_size_left,
    input  stall_from_decode, issue_queue_element, issue_queue_push_number
  );

  modport slave (
    input  flush, in_valid, decode_require, iq_size_left,
    output stall_from_decode, issue_queue_element, issue_queue_push_number
  );
endinterface

`default_nettype wire

// File: rtl/decode_dispatch_buffer.sv
// +--------------------------------------------------------------------+
// | decode_dispatch_buffer                                             |
// | Decodes a fetch bundle, compacts valid slots, pushes to the IQ.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module decoder (
  input  wire logic [31:0] i_instr,
  output logic      [32:0] o_elem
);
  logic w_is_rr;

  assign w_is_rr = (i_instr[6:0] == 7'b0110011);
  // {is_rr, funct7, funct3, rs2, rs1, rd, opcode}
  assign o_elem  = {w_is_rr, i_instr[31:25], i_instr[14:12], i_instr[24:20],
                    i_instr[19:15], i_instr[11:7], i_instr[6:0]};
endmodule

module decode_dispatch_buffer #(
  parameter int WIDTH   = 4,
  parameter int PARTIAL = 1,
  parameter int CNT_W   = $clog2(WIDTH + 1)
) (
  input wire logic                 clk,
  input wire logic                 rst,
  decode_dispatch_buffer_if.slave  bus
);
  localparam int               REQ_W   = 33;
  localparam int               ELEM_W  = 33;
  localparam logic [CNT_W-1:0] C_WIDTH = CNT_W'(WIDTH);

  logic [WIDTH-1:0][ELEM_W-1:0] r_hold;
  logic [WIDTH-1:0][ELEM_W-1:0] w_dec;
  logic [WIDTH-1:0][ELEM_W-1:0] w_comp;
  logic [WIDTH-1:0][ELEM_W-1:0] w_shift;
  logic [CNT_W-1:0]             r_held_cnt;
  logic [CNT_W-1:0]             w_fit;
  logic [CNT_W-1:0]             w_push;
  logic [CNT_W-1:0]             w_cnt;
  logic                         w_ready;
  logic                         w_capture;

  for (genvar g = 0; g < WIDTH; g++) begin : g_dec
    decoder u_dec (
      .i_instr (bus.decode_require[g][31:0]),
      .o_elem  (w_dec[g])
    );
  end

  always_comb begin
    w_fit = (bus.iq_size_left > C_WIDTH) ? C_WIDTH : bus.iq_size_left;
    if (bus.flush)
      w_push = '0;
    else if (PARTIAL != 0)
      w_push = (r_held_cnt < w_fit) ? r_held_cnt : w_fit;
    else
      w_push = (r_held_cnt <= w_fit) ? r_held_cnt : '0;
  end

  assign w_ready   = (r_held_cnt == w_push) || bus.flush;
  assign w_capture = bus.in_valid && w_ready && !bus.flush;

  // Each valid slot lands at the index given by the number of valid slots before it.
  always_comb begin
    w_comp = '0;
    w_cnt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (bus.decode_require[i][REQ_W-1] && (w_cnt == CNT_W'(j)))
          w_comp[j] = w_dec[i];
      end
      w_cnt = w_cnt + CNT_W'(bus.decode_require[i][REQ_W-1]);
    end
  end

  always_comb begin
    w_shift = '0;
    for (int j = 0; j < WIDTH; j++) begin
      for (int s = 0; s < WIDTH; s++) begin
        if ((CNT_W'(s) == w_push) && (j + s < WIDTH))
          w_shift[j] = r_hold[(j + s) % WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_held_cnt <= '0;
      r_hold     <= '0;
    end else if (bus.flush) begin
      r_held_cnt <= '0;
    end else if (w_capture) begin
      r_held_cnt <= w_cnt;
      r_hold     <= w_comp;
    end else begin
      r_held_cnt <= r_held_cnt - w_push;
      r_hold     <= w_shift;
    end
  end

  assign bus.issue_queue_element     = r_hold;
  assign bus.issue_queue_push_number = w_push;
  assign bus.stall_from_decode       = !w_ready;
endmodule

`default_nettype wire

// File: tb/tb_decode_dispatch_buffer.sv
// Directed bench for decode_dispatch_buffer: one PARTIAL=1 and one PARTIAL=0 instance.
`default_nettype none

module tb_decode_dispatch_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  decode_dispatch_buffer_if #(.WIDTH(4)) ifp ();
  decode_dispatch_buffer_if #(.WIDTH(4)) ifa ();

  decode_dispatch_buffer #(.WIDTH(4), .PARTIAL(1)) dut_p (.clk(clk), .rst(rst), .bus(ifp));
  decode_dispatch_buffer #(.WIDTH(4), .PARTIAL(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  function automatic logic [31:0] mk_instr(input int id);
    logic [7:0] b;
    logic [6:0] op;
    b  = 8'(id);
    op = b[0] ? 7'b0110011 : 7'b0010011;
    return {b[7:1], 5'(b + 8'd2), 5'(b + 8'd1), b[2:0], b[4:0], op};
  endfunction

  function automatic logic [32:0] mk_elem(input int id);
    logic [7:0] b;
    logic [6:0] op;
    b  = 8'(id);
    op = b[0] ? 7'b0110011 : 7'b0010011;
    return {b[0], b[7:1], b[2:0], 5'(b + 8'd2), 5'(b + 8'd1), b[4:0], op};
  endfunction

  task automatic drive_p(input logic v, input logic [3:0] m, input int base,
                         input logic [2:0] iq, input logic fl);
    for (int i = 0; i < 4; i++) ifp.decode_require[i] = {m[i], mk_instr(base + i)};
    ifp.in_valid = v; ifp.iq_size_left = iq; ifp.flush = fl;
  endtask

  task automatic drive_a(input logic v, input logic [3:0] m, input int base,
                         input logic [2:0] iq, input logic fl);
    for (int i = 0; i < 4; i++) ifa.decode_require[i] = {m[i], mk_instr(base + i)};
    ifa.in_valid = v; ifa.iq_size_left = iq; ifa.flush = fl;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_p(input string name, input int exp_push, input logic exp_stall);
    @(negedge clk);
    n_vec++;
    if (ifp.issue_queue_push_number !== 3'(exp_push)) begin
      n_bad++; $display("FAIL %s push: got %0d want %0d", name, ifp.issue_queue_push_number, exp_push);
    end
    n_vec++;
    if (ifp.stall_from_decode !== exp_stall) begin
      n_bad++; $display("FAIL %s stall: got %0b want %0b", name, ifp.stall_from_decode, exp_stall);
    end
  endtask

  task automatic chk_elem_p(input string name, input int slot, input int id);
    n_vec++;
    if (ifp.issue_queue_element[slot] !== mk_elem(id)) begin
      n_bad++; $display("FAIL %s elem[%0d]: got %h want %h", name, slot, ifp.issue_queue_element[slot], mk_elem(id));
    end
  endtask

  task automatic test_reset();
    drive_p(0, 4'b0000, 0, 3'd7, 0);
    drive_a(0, 4'b0000, 0, 3'd7, 0);
    @(negedge clk);
    n_vec++; if (ifa.issue_queue_push_number !== 3'd0) begin n_bad++; $display("FAIL reset_a push: got %0d want 0", ifa.issue_queue_push_number); end
    n_vec++; if (ifa.stall_from_decode !== 1'b0) begin n_bad++; $display("FAIL reset_a stall: got %0b want 0", ifa.stall_from_decode); end
    chk_p("reset_p", 0, 1'b0);
    step();
  endtask

  task automatic test_back_to_back();
    drive_p(1, 4'b1111, 10, 3'd7, 0);
    chk_p("b2b_first", 0, 1'b0);
    step();
    drive_p(1, 4'b1111, 20, 3'd7, 0);
    chk_p("b2b_second", 4, 1'b0);
    for (int i = 0; i < 4; i++) chk_elem_p("b2b_first", i, 10 + i);
    step();
    drive_p(0, 4'b0000, 0, 3'd7, 0);
    chk_p("b2b_drain", 4, 1'b0);
    chk_elem_p("b2b_second", 0, 20);
    chk_elem_p("b2b_second", 3, 23);
    step();
  endtask

  task automatic test_sparse();
    drive_p(1, 4'b1010, 30, 3'd7, 0);
    step();
    drive_p(1, 4'b0000, 40, 3'd7, 0);
    chk_p("sparse", 2, 1'b0);
    chk_elem_p("sparse", 0, 31);
    chk_elem_p("sparse", 1, 33);
    step();
    drive_p(0, 4'b0000, 0, 3'd7, 0);
    chk_p("empty_bundle", 0, 1'b0);
    step();
  endtask

  task automatic test_partial();
    drive_p(1, 4'b1111, 50, 3'd7, 0);
    step();
    drive_p(1, 4'b1111, 60, 3'd1, 0);
    chk_p("partial_c1", 1, 1'b1);
    step();
    drive_p(1, 4'b1111, 60, 3'd2, 0);
    chk_p("partial_c2", 2, 1'b1);
    chk_elem_p("partial_c2", 0, 51);
    step();
    drive_p(1, 4'b1111, 60, 3'd4, 0);
    chk_p("partial_c3", 1, 1'b0);
    chk_elem_p("partial_c3", 0, 53);
    step();
    drive_p(0, 4'b0000, 0, 3'd7, 0);
    chk_p("partial_next", 4, 1'b0);
    chk_elem_p("partial_next", 0, 60);
    chk_elem_p("partial_next", 3, 63);
    step();
  endtask

  task automatic test_all_or_nothing();
    drive_a(1, 4'b1111, 70, 3'd7, 0);
    step();
    drive_a(1, 4'b1111, 80, 3'd3, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++; if (ifa.issue_queue_push_number !== 3'd0) begin n_bad++; $display("FAIL aon_wait%0d push: got %0d want 0", c, ifa.issue_queue_push_number); end
      n_vec++; if (ifa.stall_from_decode !== 1'b1) begin n_bad++; $display("FAIL aon_wait%0d stall: got %0b want 1", c, ifa.stall_from_decode); end
      step();
    end
    drive_a(1, 4'b1111, 80, 3'd4, 0);
    @(negedge clk);
    n_vec++; if (ifa.issue_queue_push_number !== 3'd4) begin n_bad++; $display("FAIL aon_fit push: got %0d want 4", ifa.issue_queue_push_number); end
    n_vec++; if (ifa.stall_from_decode !== 1'b0) begin n_bad++; $display("FAIL aon_fit stall: got %0b want 0", ifa.stall_from_decode); end
    n_vec++; if (ifa.issue_queue_element[3] !== mk_elem(73)) begin n_bad++; $display("FAIL aon_fit elem[3]: got %h want %h", ifa.issue_queue_element[3], mk_elem(73)); end
    step();
    drive_a(0, 4'b0000, 0, 3'd7, 0);
    @(negedge clk);
    n_vec++; if (ifa.issue_queue_element[0] !== mk_elem(80)) begin n_bad++; $display("FAIL aon_next elem[0]: got %h want %h", ifa.issue_queue_element[0], mk_elem(80)); end
    n_vec++; if (ifa.issue_queue_push_number !== 3'd4) begin n_bad++; $display("FAIL aon_next push: got %0d want 4", ifa.issue_queue_push_number); end
    step();
  endtask

  task automatic test_flush();
    drive_p(1, 4'b1111, 90, 3'd7, 0);
    step();
    drive_p(0, 4'b0000, 0, 3'd1, 0);
    step();
    drive_p(1, 4'b1111, 100, 3'd4, 1);
    chk_p("flush_cycle", 0, 1'b0);
    step();
    drive_p(0, 4'b0000, 0, 3'd7, 0);
    chk_p("flush_after", 0, 1'b0);
    step();
    chk_p("flush_dropped", 0, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    drive_p(1, 4'b1111, 110, 3'd7, 0);
    step();
    drive_p(0, 4'b0000, 0, 3'd2, 0);
    step();
    rst = 1'b1;
    drive_p(0, 4'b0000, 0, 3'd0, 0);
    step();
    rst = 1'b0;
    drive_p(0, 4'b0000, 0, 3'd7, 0);
    chk_p("rst_mid", 0, 1'b0);
    drive_p(1, 4'b1111, 120, 3'd7, 0);
    step();
    drive_p(0, 4'b0000, 0, 3'd7, 0);
    chk_p("rst_recapture", 4, 1'b0);
    chk_elem_p("rst_recapture", 0, 120);
    chk_elem_p("rst_recapture", 3, 123);
    step();
  endtask

  initial begin
    drive_p(0, 4'b0000, 0, 3'd0, 0);
    drive_a(0, 4'b0000, 0, 3'd0, 0);
    repeat (2) step();
    rst = 1'b0;
    test_reset();
    test_back_to_back();
    test_sparse();
    test_partial();
    test_all_or_nothing();
    test_flush();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
